// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: shared types and encodings for the RV32I decode stage.
// Holds the ALU/debug enums, RV32I opcode/funct encodings, the decoded
// control struct and immediate-assembly helpers.
package rv_decode_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SLL  = 3'd1,
      ALU_SLT  = 3'd2,
      ALU_SLTU = 3'd3,
      ALU_XOR  = 3'd4,
      ALU_SR   = 3'd5,
      ALU_OR   = 3'd6,
      ALU_AND  = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      DBG_OK      = 2'd0,
      DBG_ILLEGAL = 2'd1,
      DBG_HALT    = 2'd2
   } debug_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [4:0]  rs1_idx;
      logic [4:0]  rs2_idx;
      logic [4:0]  rd_idx;
      logic [31:0] imm;
      alu_op_e     alu_op;
      logic        alu_op_mod;
      logic        alu_use_imm;
      logic        alu_rs1_pc;
      logic        alu_rs2_neg;
      logic        mem_load;
      logic        mem_store;
      logic        jump_enable;
      logic        branch_enable;
      logic        reg_write;
      debug_e      debug;
   } decode_t;

   function automatic logic [31:0] imm_i(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[31:25], inst[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] inst);
      return {inst[31:12], 12'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/rv_gp_regfile.sv
// rv_gp_regfile: 31 x 32-bit general-purpose registers (x0 hardwired to 0),
// two combinational read ports, one write port committed at posedge.
// Optional macro GPR_WRITE_BYPASS_EN forwards a same-cycle write to the reads.
module rv_gp_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_we,
   input  logic [4:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_raddr_a,
   input  logic [4:0]  i_raddr_b,
   output logic [31:0] o_rdata_a,
   output logic [31:0] o_rdata_b
);

   logic [31:0] r_gpr [1:31];

   // Storage: cleared on reset, x0 writes dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) r_gpr[i] <= '0;
      end else if (i_we && (i_waddr != 5'd0)) begin
         r_gpr[i_waddr] <= i_wdata;
      end
   end

   // Read ports: x0 reads zero; optionally forward the pending write.
   always_comb begin
      o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_gpr[i_raddr_a];
      o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_gpr[i_raddr_b];
`ifdef GPR_WRITE_BYPASS_EN
      if (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
      if (i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
`endif
   end

endmodule

// File: rtl/rv_hazard_detect.sv
// rv_hazard_detect: RAW scoreboard of in-flight destinations plus a
// control-transfer penalty counter; raises stall while either blocks issue.
// With GPR_WRITE_BYPASS_EN the oldest (writeback) entry is not matched,
// since the register file forwards that value.
module rv_hazard_detect #(
   parameter int HAZARD_DEPTH   = 3,
   parameter int BRANCH_PENALTY = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] i_rs1_idx,
   input  logic [4:0] i_rs2_idx,
   input  logic [4:0] i_rd_idx,
   input  logic       i_reg_write,
   input  logic       i_ctrl_xfer,
   output logic       o_stall
);

`ifdef GPR_WRITE_BYPASS_EN
   localparam int MATCH_DEPTH = HAZARD_DEPTH - 1;
`else
   localparam int MATCH_DEPTH = HAZARD_DEPTH;
`endif
   localparam int CNT_W = (BRANCH_PENALTY < 1) ? 1 : $clog2(BRANCH_PENALTY + 1);

   logic [HAZARD_DEPTH-1:0] r_sb_valid;
   logic [4:0]              r_sb_rd [HAZARD_DEPTH];
   logic [CNT_W-1:0]        r_br_cnt;
   logic                    w_raw;
   logic                    w_stall;

   // Unused source indices arrive as 0 and never match.
   always_comb begin
      w_raw = 1'b0;
      for (int i = 0; i < MATCH_DEPTH; i++) begin
         if (r_sb_valid[i] &&
             (((i_rs1_idx != 5'd0) && (i_rs1_idx == r_sb_rd[i])) ||
              ((i_rs2_idx != 5'd0) && (i_rs2_idx == r_sb_rd[i]))))
            w_raw = 1'b1;
      end
   end

   assign w_stall = w_raw || (r_br_cnt != '0);
   assign o_stall = w_stall;

   // Scoreboard shifts every cycle; a stalled slot enters as a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sb_valid <= '0;
         for (int i = 0; i < HAZARD_DEPTH; i++) r_sb_rd[i] <= 5'd0;
      end else begin
         r_sb_valid[0] <= i_reg_write && (i_rd_idx != 5'd0) && !w_stall;
         r_sb_rd[0]    <= i_rd_idx;
         for (int i = 1; i < HAZARD_DEPTH; i++) begin
            r_sb_valid[i] <= r_sb_valid[i-1];
            r_sb_rd[i]    <= r_sb_rd[i-1];
         end
      end
   end

   // Penalty counter: armed by an issued jump/branch, counts down to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_br_cnt <= '0;
      end else if (i_ctrl_xfer && !w_stall) begin
         r_br_cnt <= CNT_W'(BRANCH_PENALTY);
      end else if (r_br_cnt != '0) begin
         r_br_cnt <= r_br_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/rv_decode_unit.sv
// rv_decode_unit: RV32I decode stage - combinational decoder, GPR file and
// hazard detector. Optional macro GPR_WRITE_BYPASS_EN enables same-cycle
// writeback forwarding in the register file (and shortens the RAW window).
module rv_decode_unit
   import rv_decode_pkg::*;
#(
   parameter int HAZARD_DEPTH   = 3,
   parameter int BRANCH_PENALTY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        write_enable,
   input  logic [4:0]  write_idx,
   input  logic [31:0] write_data,
   output logic [4:0]  rs1_idx,
   output logic [4:0]  rs2_idx,
   output logic [4:0]  rd_idx,
   output logic [31:0] rs1_val,
   output logic [31:0] rs2_val,
   output logic [31:0] imm,
   output logic [2:0]  alu_op,
   output logic        alu_op_mod,
   output logic        alu_use_imm,
   output logic        alu_rs1_pc,
   output logic        alu_rs2_neg,
   output logic        mem_load,
   output logic        mem_store,
   output logic        jump_enable,
   output logic        branch_enable,
   output logic        reg_write,
   output logic [1:0]  debug,
   output logic        stall
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_rd;
   decode_t    w_dec;
   logic       w_illegal;
   logic       w_halt;

   assign w_opcode = instruction[6:0];
   assign w_rd     = instruction[11:7];
   assign w_funct3 = instruction[14:12];
   assign w_rs1    = instruction[19:15];
   assign w_rs2    = instruction[24:20];
   assign w_funct7 = instruction[31:25];

   // Decoder: fields left at 0 when an instruction does not use them;
   // illegal or halt instructions drop every enable.
   always_comb begin
      w_dec     = '0;
      w_illegal = 1'b0;
      w_halt    = 1'b0;
      case (w_opcode)
         OPC_OP: begin
            w_dec.rs1_idx   = w_rs1;
            w_dec.rs2_idx   = w_rs2;
            w_dec.rd_idx    = w_rd;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = alu_op_e'(w_funct3);
            if ((w_funct7 == F7_ALT) && (w_funct3 == F3_ADD)) w_dec.alu_rs2_neg = 1'b1;
            else if ((w_funct7 == F7_ALT) && (w_funct3 == F3_SR)) w_dec.alu_op_mod = 1'b1;
            else if (w_funct7 != F7_BASE) w_illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            w_dec.rs1_idx     = w_rs1;
            w_dec.rd_idx      = w_rd;
            w_dec.imm         = imm_i(instruction);
            w_dec.alu_use_imm = 1'b1;
            w_dec.reg_write   = 1'b1;
            w_dec.alu_op      = alu_op_e'(w_funct3);
            if (w_funct3 == F3_SLL) w_illegal = (w_funct7 != F7_BASE);
            else if (w_funct3 == F3_SR) begin
               if (w_funct7 == F7_ALT) w_dec.alu_op_mod = 1'b1;
               else if (w_funct7 != F7_BASE) w_illegal = 1'b1;
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            w_dec.rd_idx      = w_rd;
            w_dec.imm         = imm_u(instruction);
            w_dec.alu_use_imm = 1'b1;
            w_dec.alu_rs1_pc  = (w_opcode == OPC_AUIPC);
            w_dec.reg_write   = 1'b1;
         end
         OPC_LOAD: begin
            w_dec.rs1_idx     = w_rs1;
            w_dec.rd_idx      = w_rd;
            w_dec.imm         = imm_i(instruction);
            w_dec.alu_use_imm = 1'b1;
            w_dec.mem_load    = 1'b1;
            w_dec.reg_write   = 1'b1;
            w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
         end
         OPC_STORE: begin
            w_dec.rs1_idx     = w_rs1;
            w_dec.rs2_idx     = w_rs2;
            w_dec.imm         = imm_s(instruction);
            w_dec.alu_use_imm = 1'b1;
            w_dec.mem_store   = 1'b1;
            w_illegal = w_funct3[2] || (w_funct3[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            w_dec.rs1_idx       = w_rs1;
            w_dec.rs2_idx       = w_rs2;
            w_dec.imm           = imm_b(instruction);
            w_dec.branch_enable = 1'b1;
            w_dec.alu_op_mod    = w_funct3[0];
            case (w_funct3[2:1])
               2'b00:   w_dec.alu_op = ALU_XOR;
               2'b10:   w_dec.alu_op = ALU_SLT;
               2'b11:   w_dec.alu_op = ALU_SLTU;
               default: w_illegal = 1'b1;
            endcase
         end
         // Link value is the incoming pc (already +4): pc + x0.
         OPC_JAL, OPC_JALR: begin
            w_dec.rs1_idx     = (w_opcode == OPC_JALR) ? w_rs1 : 5'd0;
            w_dec.rd_idx      = w_rd;
            w_dec.imm         = (w_opcode == OPC_JALR) ? imm_i(instruction) : imm_j(instruction);
            w_dec.jump_enable = 1'b1;
            w_dec.alu_rs1_pc  = 1'b1;
            w_dec.reg_write   = 1'b1;
            w_illegal = (w_opcode == OPC_JALR) && (w_funct3 != 3'b000);
         end
         OPC_SYSTEM: begin
            if ((instruction[31:21] == 11'd0) && (instruction[19:7] == 13'd0)) w_halt = 1'b1;
            else w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (w_illegal || w_halt) begin
         w_dec       = '0;
         w_dec.debug = w_illegal ? DBG_ILLEGAL : DBG_HALT;
      end
   end

   assign rs1_idx       = w_dec.rs1_idx;
   assign rs2_idx       = w_dec.rs2_idx;
   assign rd_idx        = w_dec.rd_idx;
   assign imm           = w_dec.imm;
   assign alu_op        = w_dec.alu_op;
   assign alu_op_mod    = w_dec.alu_op_mod;
   assign alu_use_imm   = w_dec.alu_use_imm;
   assign alu_rs1_pc    = w_dec.alu_rs1_pc;
   assign alu_rs2_neg   = w_dec.alu_rs2_neg;
   assign mem_load      = w_dec.mem_load;
   assign mem_store     = w_dec.mem_store;
   assign jump_enable   = w_dec.jump_enable;
   assign branch_enable = w_dec.branch_enable;
   assign reg_write     = w_dec.reg_write;
   assign debug         = w_dec.debug;

   rv_gp_regfile u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (write_enable),
      .i_waddr   (write_idx),
      .i_wdata   (write_data),
      .i_raddr_a (w_dec.rs1_idx),
      .i_raddr_b (w_dec.rs2_idx),
      .o_rdata_a (rs1_val),
      .o_rdata_b (rs2_val)
   );

   rv_hazard_detect #(
      .HAZARD_DEPTH   (HAZARD_DEPTH),
      .BRANCH_PENALTY (BRANCH_PENALTY)
   ) u_hazard (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_rs1_idx   (w_dec.rs1_idx),
      .i_rs2_idx   (w_dec.rs2_idx),
      .i_rd_idx    (w_dec.rd_idx),
      .i_reg_write (w_dec.reg_write),
      .i_ctrl_xfer (w_dec.jump_enable | w_dec.branch_enable),
      .o_stall     (stall)
   );

endmodule

// File: tb/tb_rv_decode_unit.sv
// tb_rv_decode_unit: directed vectors for rv_decode_unit. The driver applies
// one instruction per cycle and queues the expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_rv_decode_unit;

   typedef struct packed {
      logic [4:0]  rs1_idx;
      logic [4:0]  rs2_idx;
      logic [4:0]  rd_idx;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [2:0]  alu_op;
      logic        mod;
      logic        use_imm;
      logic        rs1_pc;
      logic        rs2_neg;
      logic        load;
      logic        store;
      logic        jump;
      logic        branch;
      logic        reg_write;
      logic [1:0]  debug;
      logic        stall;
   } obs_t;

   localparam int OW = $bits(obs_t);

`ifdef GPR_WRITE_BYPASS_EN
   localparam int  STALL_CYC = 2;
   localparam bit  BYPASS    = 1'b1;
`else
   localparam int  STALL_CYC = 3;
   localparam bit  BYPASS    = 1'b0;
`endif

   localparam logic [2:0] A_ADD = 3'd0, A_SLT = 3'd2, A_SLTU = 3'd3, A_XOR = 3'd4, A_SR = 3'd5, A_AND = 3'd7;
   localparam logic [8:0] F_MOD = 9'h100, F_IMM = 9'h080, F_PC = 9'h040, F_NEG = 9'h020;
   localparam logic [8:0] F_LD  = 9'h010, F_ST  = 9'h008, F_JMP = 9'h004, F_BR = 9'h002, F_RW = 9'h001;
   localparam logic [1:0] D_OK = 2'd0, D_ILL = 2'd1, D_HALT = 2'd2;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic        write_enable;
   logic [4:0]  write_idx;
   logic [31:0] write_data;
   logic [4:0]  rs1_idx, rs2_idx, rd_idx;
   logic [31:0] rs1_val, rs2_val, imm;
   logic [2:0]  alu_op;
   logic        alu_op_mod, alu_use_imm, alu_rs1_pc, alu_rs2_neg;
   logic        mem_load, mem_store, jump_enable, branch_enable, reg_write;
   logic [1:0]  debug;
   logic        stall;

   logic [OW-1:0] exp_q[$];
   logic [OW-1:0] msk_q[$];
   string         name_q[$];
   logic          obs_req;
   logic          rst_drv;
   int            n_vec;
   int            n_err;
   logic [OW-1:0] act_v;

   rv_decode_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instruction   (instruction),
      .write_enable  (write_enable),
      .write_idx     (write_idx),
      .write_data    (write_data),
      .rs1_idx       (rs1_idx),
      .rs2_idx       (rs2_idx),
      .rd_idx        (rd_idx),
      .rs1_val       (rs1_val),
      .rs2_val       (rs2_val),
      .imm           (imm),
      .alu_op        (alu_op),
      .alu_op_mod    (alu_op_mod),
      .alu_use_imm   (alu_use_imm),
      .alu_rs1_pc    (alu_rs1_pc),
      .alu_rs2_neg   (alu_rs2_neg),
      .mem_load      (mem_load),
      .mem_store     (mem_store),
      .jump_enable   (jump_enable),
      .branch_enable (branch_enable),
      .reg_write     (reg_write),
      .debug         (debug),
      .stall         (stall)
   );

   assign act_v = {rs1_idx, rs2_idx, rd_idx, rs1_val, rs2_val, imm, alu_op,
                   alu_op_mod, alu_use_imm, alu_rs1_pc, alu_rs2_neg, mem_load,
                   mem_store, jump_enable, branch_enable, reg_write, debug, stall};

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] im, input logic [2:0] op, input logic [8:0] fl,
                               input logic [1:0] dbg, input logic stl);
      obs_t o;
      o = '0;
      o.rs1_idx = rs1;
      o.rs2_idx = rs2;
      o.rd_idx  = rd;
      o.imm     = im;
      o.alu_op  = op;
      {o.mod, o.use_imm, o.rs1_pc, o.rs2_neg, o.load, o.store, o.jump, o.branch, o.reg_write} = fl;
      o.debug   = dbg;
      o.stall   = stl;
      return o;
   endfunction

   // Driver: one call = one cycle of stimulus, optionally with an expectation.
   task automatic step(input logic [31:0] inst, input logic we, input logic [4:0] widx,
                       input logic [31:0] wdata, input logic do_chk, input obs_t e,
                       input obs_t m, input string nm);
      @(posedge clk);
      #1;
      rst_n        = rst_drv;
      instruction  = inst;
      write_enable = we;
      write_idx    = widx;
      write_data   = wdata;
      obs_req      = do_chk;
      if (do_chk) begin
         exp_q.push_back(e);
         msk_q.push_back(m);
         name_q.push_back(nm);
      end
   endtask

   task automatic chk(input logic [31:0] inst, input obs_t e, input string nm);
      step(inst, 1'b0, 5'd0, 32'd0, 1'b1, e, '1, nm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(32'd0, 1'b0, 5'd0, 32'd0, 1'b0, '0, '0, "");
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] data);
      step(32'd0, 1'b1, idx, data, 1'b0, '0, '0, "");
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (obs_req) begin
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL no_expectation: got %h required an queued entry", act_v);
         end else begin
            logic [OW-1:0] e_v;
            logic [OW-1:0] m_v;
            string         nm;
            e_v = exp_q.pop_front();
            m_v = msk_q.pop_front();
            nm  = name_q.pop_front();
            n_vec++;
            if ((act_v & m_v) !== (e_v & m_v)) begin
               n_err++;
               $display("FAIL %s: got %h required %h", nm, act_v & m_v, e_v & m_v);
            end
         end
      end
   end

   logic [31:0] tv_inst [19];
   obs_t        tv_exp  [19];

   initial begin
      obs_t e;
      n_vec = 0;
      n_err = 0;
      obs_req = 1'b0;
      rst_drv = 1'b0;
      rst_n = 1'b0;
      instruction = 32'd0;
      write_enable = 1'b0;
      write_idx = 5'd0;
      write_data = 32'd0;

      tv_inst[0]  = 32'h00500093; tv_exp[0]  = mk(5'd0, 5'd0, 5'd1, 32'd5, A_ADD, F_IMM | F_RW, D_OK, 1'b0);
      tv_inst[1]  = 32'h407302B3; tv_exp[1]  = mk(5'd6, 5'd7, 5'd5, 32'd0, A_ADD, F_NEG | F_RW, D_OK, 1'b0);
      tv_inst[2]  = 32'h4030D093; tv_exp[2]  = mk(5'd1, 5'd0, 5'd1, 32'h403, A_SR, F_MOD | F_IMM | F_RW, D_OK, 1'b0);
      tv_inst[3]  = 32'hFFFFFFFF; tv_exp[3]  = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_ILL, 1'b0);
      tv_inst[4]  = 32'h12345537; tv_exp[4]  = mk(5'd0, 5'd0, 5'd10, 32'h12345000, A_ADD, F_IMM | F_RW, D_OK, 1'b0);
      tv_inst[5]  = 32'hFFFFF197; tv_exp[5]  = mk(5'd0, 5'd0, 5'd3, 32'hFFFFF000, A_ADD, F_PC | F_IMM | F_RW, D_OK, 1'b0);
      tv_inst[6]  = 32'hFFC12203; tv_exp[6]  = mk(5'd2, 5'd0, 5'd4, 32'hFFFFFFFC, A_ADD, F_IMM | F_LD | F_RW, D_OK, 1'b0);
      tv_inst[7]  = 32'h00532623; tv_exp[7]  = mk(5'd6, 5'd5, 5'd0, 32'd12, A_ADD, F_IMM | F_ST, D_OK, 1'b0);
      tv_inst[8]  = 32'hFE209EE3; tv_exp[8]  = mk(5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, A_XOR, F_MOD | F_BR, D_OK, 1'b0);
      tv_inst[9]  = 32'h0041F863; tv_exp[9]  = mk(5'd3, 5'd4, 5'd0, 32'd16, A_SLTU, F_MOD | F_BR, D_OK, 1'b0);
      tv_inst[10] = 32'h009423B3; tv_exp[10] = mk(5'd8, 5'd9, 5'd7, 32'd0, A_SLT, F_RW, D_OK, 1'b0);
      tv_inst[11] = 32'h001000EF; tv_exp[11] = mk(5'd0, 5'd0, 5'd1, 32'h800, A_ADD, F_PC | F_JMP | F_RW, D_OK, 1'b0);
      tv_inst[12] = 32'h00008067; tv_exp[12] = mk(5'd1, 5'd0, 5'd0, 32'd0, A_ADD, F_PC | F_JMP | F_RW, D_OK, 1'b0);
      tv_inst[13] = 32'h00000073; tv_exp[13] = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_HALT, 1'b0);
      tv_inst[14] = 32'h00100073; tv_exp[14] = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_HALT, 1'b0);
      tv_inst[15] = 32'h02000033; tv_exp[15] = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_ILL, 1'b0);
      tv_inst[16] = 32'h40009093; tv_exp[16] = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_ILL, 1'b0);
      tv_inst[17] = 32'h00002063; tv_exp[17] = mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_ILL, 1'b0);
      tv_inst[18] = 32'h403150B3; tv_exp[18] = mk(5'd2, 5'd3, 5'd1, 32'd0, A_SR, F_MOD | F_RW, D_OK, 1'b0);

      // Reset state (instruction 0 is not a valid opcode)
      chk(32'd0, mk(5'd0, 5'd0, 5'd0, 32'd0, A_ADD, 9'h000, D_ILL, 1'b0), "reset_state");
      rst_drv = 1'b1;
      idle(1);

      // Decode table, each vector followed by enough idle cycles to drain hazards
      for (int i = 0; i < 19; i++) begin
         chk(tv_inst[i], tv_exp[i], $sformatf("decode_%0d", i));
         idle(3);
      end

      // RAW hazard: addi x1 then add x2,x1,x1
      chk(32'h00500093, mk(5'd0, 5'd0, 5'd1, 32'd5, A_ADD, F_IMM | F_RW, D_OK, 1'b0), "raw_producer");
      for (int k = 0; k < STALL_CYC; k++)
         chk(32'h00108133, mk(5'd1, 5'd1, 5'd2, 32'd0, A_ADD, F_RW, D_OK, 1'b1), $sformatf("raw_stall_%0d", k));
      chk(32'h00108133, mk(5'd1, 5'd1, 5'd2, 32'd0, A_ADD, F_RW, D_OK, 1'b0), "raw_release");

      // Branch penalty: beq x0,x0,8
      chk(32'h00000463, mk(5'd0, 5'd0, 5'd0, 32'd8, A_XOR, F_BR, D_OK, 1'b0), "beq_issue");
      chk(32'h00000463, mk(5'd0, 5'd0, 5'd0, 32'd8, A_XOR, F_BR, D_OK, 1'b1), "beq_penalty_1");
      chk(32'h00000463, mk(5'd0, 5'd0, 5'd0, 32'd8, A_XOR, F_BR, D_OK, 1'b1), "beq_penalty_2");
      chk(32'h407302B3, mk(5'd6, 5'd7, 5'd5, 32'd0, A_ADD, F_NEG | F_RW, D_OK, 1'b0), "after_branch");
      idle(3);

      // Register file write / read
      wr(5'd3, 32'hDEADBEEF);
      e = mk(5'd3, 5'd0, 5'd4, 32'd0, A_ADD, F_RW, D_OK, 1'b0);
      e.rs1_val = 32'hDEADBEEF;
      chk(32'h00018233, e, "gpr_read_x3");
      e.rs1_val = BYPASS ? 32'h12345678 : 32'hDEADBEEF;
      step(32'h00018233, 1'b1, 5'd3, 32'h12345678, 1'b1, e, '1, "gpr_same_cycle_write");
      e.rs1_val = 32'h12345678;
      chk(32'h00018233, e, "gpr_read_after_write");
      wr(5'd0, 32'hFFFFFFFF);
      chk(32'h00000333, mk(5'd0, 5'd0, 5'd6, 32'd0, A_ADD, F_RW, D_OK, 1'b0), "gpr_x0_reads_zero");
      wr(5'd31, 32'h000000A5);
      e = mk(5'd0, 5'd31, 5'd8, 32'd0, A_AND, F_RW, D_OK, 1'b0);
      e.rs2_val = 32'h000000A5;
      chk(32'h01F07433, e, "gpr_read_x31");

      // Asynchronous reset in the middle of a stall
      chk(32'h00100193, mk(5'd0, 5'd0, 5'd3, 32'd1, A_ADD, F_IMM | F_RW, D_OK, 1'b0), "rst_producer");
      e = mk(5'd3, 5'd31, 5'd4, 32'd0, A_ADD, F_RW, D_OK, 1'b1);
      e.rs1_val = 32'h12345678;
      e.rs2_val = 32'h000000A5;
      chk(32'h01F18233, e, "rst_pre_stall");
      rst_drv = 1'b0;
      chk(32'h01F18233, mk(5'd3, 5'd31, 5'd4, 32'd0, A_ADD, F_RW, D_OK, 1'b0), "rst_async_clear");
      rst_drv = 1'b1;
      chk(32'h01F18233, mk(5'd3, 5'd31, 5'd4, 32'd0, A_ADD, F_RW, D_OK, 1'b0), "rst_after_release");
      idle(1);

      for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rv_decode_unit.md
Name: rv_decode_unit

Overview:
- RV32I decode-stage core: combinational instruction decoder, 32x32 general-purpose register file and a RAW/control hazard detector.
- Sits between fetch and the decode→execute pipeline register.
- The surrounding stage registers its outputs, replacing them with a bubble when `stall`=1.

Parameters:
- HAZARD_DEPTH, 3: number of in-flight stages (EX, MEM, WB) whose destination registers block reads.
- BRANCH_PENALTY, 2: stall cycles after an issued jump/branch.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instruction  in  32  instruction word in decode.
- write_enable  in  1  writeback write strobe.
- write_idx  in  5  writeback register index.
- write_data  in  32  writeback data.
- rs1_idx / rs2_idx / rd_idx  out  5 each  decoded register indices; 0 when unused.
- rs1_val / rs2_val  out  32 each  register file read data.
- imm  out  32  sign-extended immediate.
- alu_op  out  3  ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SR=5, OR=6, AND=7.
- alu_op_mod  out  1  SRA, or inverted branch condition.
- alu_use_imm  out  1  ALU operand B = imm.
- alu_rs1_pc  out  1  ALU operand A = pc.
- alu_rs2_neg  out  1  negate operand B (SUB).
- mem_load, mem_store, jump_enable, branch_enable, reg_write  out  1 each  control flags.
- debug  out  2  OK=0, ILLEGAL=1, HALT=2.
- stall  out  1  hazard: hold fetch, insert bubble.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset: all 31 registers cleared to 0; hazard scoreboard invalidated; branch counter cleared. `stall`=0 immediately.
- Decode outputs are combinational from `instruction`, 0-cycle latency.
- Immediates (I/S/B/U/J): bits assembled per RV32I and sign-extended; U-type = {inst[31:12], 12'b0}.
- OP / OP-IMM:
  - `alu_op` = funct3.
  - SUB: ADD with `alu_rs2_neg`=1.
  - SRA/SRAI: `alu_op_mod`=1.
  - OP-IMM sets `alu_use_imm`.
- LUI: ADD, rs1_idx=0, use_imm.
- AUIPC: ADD, rs1_pc, use_imm.
- LOAD: ADD, use_imm, mem_load, reg_write.
- STORE: ADD, use_imm, mem_store, reg_write=0.
- BRANCH: branch_enable, reg_write=0, alu_op/mod as follows:
  - BEQ → XOR/0; BNE → XOR/1.
  - BLT → SLT/0; BGE → SLT/1.
  - BLTU → SLTU/0; BGEU → SLTU/1.
- JAL/JALR:
  - jump_enable, reg_write, ADD, rs1_pc=1, use_imm=0, rs2_idx=0.
  - The link value is the incoming pc, already +4.
  - JALR also reports rs1_idx.
- ECALL/EBREAK: debug=HALT, all enables 0.
- Unknown opcode or funct: debug=ILLEGAL, all enables 0.
- Register file reads are combinational. Index 0 always reads 0; writes to x0 are ignored.
- Register file writes happen at posedge when `write_enable`=1.
- Scoreboard:
  - HAZARD_DEPTH-entry shift register of {valid, rd}, shifting every posedge.
  - New entry is valid only if reg_write=1, rd≠0 and stall=0.
- stall=1 when any of the following holds:
  - A used, nonzero rs1/rs2 matches a valid scoreboard entry.
  - The branch counter is ≠0.
- Branch counter: loaded with BRANCH_PENALTY when jump_enable|branch_enable and stall=0; decremented per cycle to 0.
- A simultaneous writeback to a matching register does not clear the stall; the entry must age out.

Optional Feature:
- GPR_WRITE_BYPASS_EN.
- Defined: if write_enable and write_idx (≠0) equals a read index in the same cycle, the read returns write_data. Scoreboard depth reduces effectively by one (the WB entry is excluded from matching).
- Undefined: the read returns the old value until the next cycle.

Decomposition:
- Package rv_decode_pkg: alu_op enum, debug enum, opcode/funct3/funct7 localparams, decode output struct.
- Natural sub-modules: rv_gp_regfile (storage and bypass) and rv_hazard_detect.

Test Plan:
- Reset then `instruction`=0x00500093 (addi x1,x0,5) → rd_idx=1, imm=5, alu_op=ADD, use_imm=1, reg_write=1, stall=0.
- Write x3=0xDEADBEEF at one posedge, then decode add x4,x3,x0 after the scoreboard clears → rs1_val=0xDEADBEEF. Write to x0 → read 0.
- addi x1 issued, next cycle add x2,x1,x1 → stall=1 for HAZARD_DEPTH cycles, then 0.
- beq x0,x0,8 (0x00000463) → branch_enable=1, XOR/mod 0, imm=8; stall=1 next 2 cycles.
- sub x5,x6,x7 → alu_rs2_neg=1. srai x1,x1,3 → SR with mod=1, imm[4:0]=3. 0xFFFFFFFF → debug=ILLEGAL, enables 0.
- Assert rst_n low mid-stall → stall=0 asynchronously; all registers read 0.
